serial_subtractor: RTL and testbench

//  - Bit-serial WIDTH-bit subtractor: D = A - B - b_in, computed LSB-first with one full-subtractor cell and one borrow flop.
//  - Inverse operation to the team's ripple-carry adder. Trades area for latency: one difference bit is produced per clock.
//  - Sits in the datapath as a multi-cycle arithmetic unit with a start/busy/done handshake.

---
 rtl/serial_subtractor.sv | 133 +++++++++++++
 tb/tb_serial_subtractor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (D = A - B - b_in), LSB-first, one bit per clock.
// Optional signed-overflow output enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done,
`ifdef SUB_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic [1:0]       dbg_state
);

    // Handshake: start is accepted on a rising edge whenever busy=0 (IDLE or DONE);
    // done pulses for one cycle when diff/borrow_out update, and they hold until the next result.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             bw_q, bw_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic             bit_d;
    logic             bw_next;
    logic [WIDTH-1:0] shifted;

    assign bit_d   = a_sh_q[0] ^ b_sh_q[0] ^ bw_q;
    assign bw_next = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bw_q);
    assign shifted = {bit_d, acc_q};

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        bw_d     = bw_q;
        acc_d    = acc_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_SHIFT: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                bw_d    = bw_next;
                acc_d   = shifted[WIDTH-1:1];
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    // On the last edge the shift registers hold the operand MSBs.
                    diff_d   = shifted;
                    borrow_d = bw_next;
`ifdef SUB_OVERFLOW_EN
                    ovf_d    = (a_sh_q[0] ^ b_sh_q[0]) & (a_sh_q[0] ^ bit_d);
`endif
                    state_d  = S_DONE;
                end
            end
            default: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    bw_d    = b_in;
                    count_d = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            bw_q     <= 1'b0;
            acc_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            bw_q     <= bw_d;
            acc_q    <= acc_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign busy       = (state_q == S_SHIFT);
    assign done       = (state_q == S_DONE);
    assign dbg_state  = state_q;
`ifdef SUB_OVERFLOW_EN
    assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4); checks overflow when SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         b_in = 1'b0;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;
`ifdef SUB_OVERFLOW_EN
    logic         overflow;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .b_in       (b_in),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done),
`ifdef SUB_OVERFLOW_EN
        .overflow   (overflow),
`endif
        .dbg_state  (dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [W+1:0] exp_q[$];          // {overflow, borrow, diff}
    logic [W+1:0] held = '0;
    int           busy_run = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, got, expv, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the unsigned and signed views.
    function automatic logic [W+1:0] model(input int av, input int bv, input int bi);
        int           r;
        int           sa;
        int           sb;
        int           sr;
        logic [W-1:0] d;
        logic         brw;
        logic         ov;
        r   = av - bv - bi;
        d   = W'(r);
        brw = (av < bv + bi);
        sa  = (av >= 2 ** (W - 1)) ? av - 2 ** W : av;
        sb  = (bv >= 2 ** (W - 1)) ? bv - 2 ** W : bv;
        sr  = sa - sb - bi;
        ov  = (sr < -(2 ** (W - 1))) || (sr > 2 ** (W - 1) - 1);
        return {ov, brw, d};
    endfunction

    // Driver: called at a falling edge; drives start for one rising edge.
    task automatic issue(input int av, input int bv, input int bi);
        a     = W'(av);
        b     = W'(bv);
        b_in  = bi[0];
        start = 1'b1;
        if (!busy) exp_q.push_back(model(av, bv, bi));
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        b_in  = 1'($urandom);
    endtask

    task automatic wait_quiet();
        int i;
        for (i = 0; i < 100 && (exp_q.size() != 0 || busy || done); i++) @(negedge clk);
        if (i >= 100) begin
            checks++;
            errors++;
            $display("FAIL wait_quiet_timeout: got %0d pending results required 0", exp_q.size());
        end
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 50 && !done; i++) @(negedge clk);
        if (i >= 50) begin
            checks++;
            errors++;
            $display("FAIL wait_done_timeout: got done=0 required 1");
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic [W+1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (busy) busy_run++;
                if (done) begin
                    check("busy_cycles", busy_run, W);
                    check("busy_in_done", busy, 0);
                    busy_run = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 required no pending result");
                    end else begin
                        e = exp_q.pop_front();
                        check("diff", diff, e[W-1:0]);
                        check("borrow_out", borrow_out, e[W]);
`ifdef SUB_OVERFLOW_EN
                        check("overflow", overflow, e[W+1]);
`endif
                        held = e;
                    end
                end else begin
                    check("diff_hold", diff, held[W-1:0]);
                    check("borrow_hold", borrow_out, held[W]);
`ifdef SUB_OVERFLOW_EN
                    check("overflow_hold", overflow, held[W+1]);
`endif
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_diff"}, diff, 0);
        check({tag, "_borrow"}, borrow_out, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_state"}, dbg_state, 0);
`ifdef SUB_OVERFLOW_EN
        check({tag, "_overflow"}, overflow, 0);
`endif
    endtask

    initial begin
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic, underflow, borrow-in then back-to-back
        issue(9, 3, 0);
        wait_quiet();
        issue(3, 9, 0);
        wait_quiet();
        issue(0, 0, 1);
        wait_done();
        issue(5, 5, 0);
        wait_quiet();

        // Start while busy is ignored
        issue(8, 1, 0);
        @(negedge clk);
        issue(2, 1, 0);
        wait_quiet();

        // Reset after two shift edges
        issue(9, 2, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        held     = '0;
        busy_run = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_done", done, 0);
        issue(6, 2, 0);
        wait_quiet();

        // Signed overflow corner cases
        issue(7, 15, 0);
        wait_quiet();
        issue(4, 1, 0);
        wait_quiet();
        issue(8, 0, 1);
        wait_quiet();
        issue(15, 15, 1);
        wait_quiet();

        // Random traffic, including starts that land while busy
        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            issue($urandom_range(0, 2 ** W - 1), $urandom_range(0, 2 ** W - 1), $urandom_range(0, 1));
        end
        wait_quiet();

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
